// File: rtl/adpcm_pkg.sv
// Shared constants, UART state encoding and width helper for the ADPCM UART
// output stage.
package adpcm_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Ceiling log2, usable in constant expressions for port and counter widths.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adpcm_uart_tx_if.sv
// Nibble stream from the ADPCM compressor (outValid / encPcm) into the
// UART output stage.
interface adpcm_uart_tx_if;
  import adpcm_pkg::*;

  logic              nib_valid;
  logic [NIB_W-1:0]  nib_data;

  modport master (output nib_valid, output nib_data);
  modport slave  (input  nib_valid, input  nib_data);

endinterface

// File: rtl/adpcm_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through read and a flush input.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module adpcm_byte_fifo
  import adpcm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [BYTE_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [BYTE_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int ADDR_W = clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with <= only, so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/adpcm_uart_tx.sv
// ADPCM output stage: synchronizes the nibble strobe, packs nibble pairs into
// bytes, buffers them and sends each byte as an 8N1 UART frame on tx.
module adpcm_uart_tx
  import adpcm_pkg::*;
#(
  parameter int CLK_DIV           = 16,
  parameter int FIFO_DEPTH        = 4,
  parameter bit FIRST_NIBBLE_HIGH = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  adpcm_uart_tx_if.slave              nib,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int                BAUD_W   = clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_DIV - 1);

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_int_n;
  logic [2:0]        vld_sync_q, vld_sync_d;
  logic              vld_edge;
  logic              half_q, half_d;
  logic [NIB_W-1:0]  held_q, held_d;
  logic              overflow_q, overflow_d;
  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              push, pop;
  logic [BYTE_W-1:0] push_byte, fifo_rd;
  logic              fifo_full, fifo_empty;

  // Reset asserts asynchronously (tx snaps high at once) but releases on a clock edge.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  // Two synchronizer flops plus one history flop for the rising-edge detect.
  assign vld_sync_d = {vld_sync_q[1:0], nib.nib_valid};
  assign vld_edge   = vld_sync_q[1] & ~vld_sync_q[2];
  assign push_byte  = FIRST_NIBBLE_HIGH ? {held_q, nib.nib_data} : {nib.nib_data, held_q};

  always_comb begin
    half_d     = half_q;
    held_d     = held_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    if (!enable) begin
      half_d     = 1'b0;
      held_d     = '0;
      overflow_d = 1'b0;
    end else if (vld_edge) begin
      if (!half_q) begin
        held_d = nib.nib_data;
        half_d = 1'b1;
      end else begin
        push   = 1'b1;
        half_d = 1'b0;
      end
    end
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && enable) begin
          pop     = 1'b1;
          shift_d = fifo_rd;
          baud_d  = BAUD_MAX;
          state_d = START;
        end
      end
      START: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d  = BAUD_MAX;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d  = BAUD_MAX;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else if (!fifo_empty && enable) begin
          // Chain straight into the next frame so queued bytes leave with no idle gap.
          pop     = 1'b1;
          shift_d = fifo_rd;
          baud_d  = BAUD_MAX;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the pin never sees decode glitches.
    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      vld_sync_q <= '0;
      half_q     <= 1'b0;
      held_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      vld_sync_q <= vld_sync_d;
      half_q     <= half_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  adpcm_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .flush   (~enable),
    .push    (push),
    .wr_data (push_byte),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_adpcm_uart_tx.sv
// Self-checking bench: two instances (fast baud / nibble-high, slow baud /
// nibble-low); a UART receiver model decodes tx and is compared to packed bytes.
module tb_adpcm_uart_tx;

  localparam int DIV_A = 4;
  localparam int DIV_B = 64;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       stop_ok;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_a, enable_b;
  logic       tx_a, tx_b, busy_a, busy_b, ovf_a, ovf_b;
  logic [2:0] lvl_a, lvl_b;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  rx_t        rx_a[$];
  rx_t        rx_b[$];

  adpcm_uart_tx_if if_a ();
  adpcm_uart_tx_if if_b ();

  adpcm_uart_tx #(.CLK_DIV(DIV_A), .FIFO_DEPTH(4), .FIRST_NIBBLE_HIGH(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .nib(if_a),
    .tx(tx_a), .busy(busy_a), .overflow(ovf_a), .fifo_level(lvl_a));

  adpcm_uart_tx #(.CLK_DIV(DIV_B), .FIFO_DEPTH(4), .FIRST_NIBBLE_HIGH(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .nib(if_b),
    .tx(tx_b), .busy(busy_b), .overflow(ovf_b), .fifo_level(lvl_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // UART receiver model for instance A: detect start edge, sample mid-bit.
  initial begin : mon_a
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx_a === 1'b0) begin
        rx_t r;
        r.start = cyc;
        repeat (DIV_A / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV_A) @(negedge clk);
          r.data[i] = tx_a;
        end
        repeat (DIV_A) @(negedge clk);
        r.stop_ok = (tx_a === 1'b1);
        rx_a.push_back(r);
      end
      prev = tx_a;
    end
  end

  initial begin : mon_b
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx_b === 1'b0) begin
        rx_t r;
        r.start = cyc;
        repeat (DIV_B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV_B) @(negedge clk);
          r.data[i] = tx_b;
        end
        repeat (DIV_B) @(negedge clk);
        r.stop_ok = (tx_b === 1'b1);
        rx_b.push_back(r);
      end
      prev = tx_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pack(input bit first_high, input logic [3:0] a, input logic [3:0] b);
    return first_high ? {a, b} : {b, a};
  endfunction

  task automatic send_a(input logic [3:0] n, output int t);
    @(negedge clk);
    if_a.nib_data  = n;
    if_a.nib_valid = 1'b1;
    t = cyc;
    repeat (2) @(negedge clk);
    if_a.nib_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_b(input logic [3:0] n, output int t);
    @(negedge clk);
    if_b.nib_data  = n;
    if_b.nib_valid = 1'b1;
    t = cyc;
    repeat (2) @(negedge clk);
    if_b.nib_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rx_a(input int n, input int budget);
    int k = 0;
    while (rx_a.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rx_a_timeout", rx_a.size() >= n, 1);
  endtask

  task automatic wait_rx_b(input int n, input int budget);
    int k = 0;
    while (rx_b.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rx_b_timeout", rx_b.size() >= n, 1);
  endtask

  initial begin : stim
    int          t, t0, st, k;
    logic [3:0]  n0, n1;
    logic [3:0]  nibs [12];
    logic [7:0]  exp_q[$];

    rst_n = 1'b0;
    enable_a = 1'b1;
    enable_b = 1'b1;
    if_a.nib_valid = 1'b0; if_a.nib_data = '0;
    if_b.nib_valid = 1'b0; if_b.nib_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_lvl_a", lvl_a, 0);
    check("rst_tx_b", tx_b, 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Fixed pair 0xA, 0x5 -> 0xA5, start-bit latency, frame length via busy drop
    send_a(4'hA, t0);
    send_a(4'h5, t);
    wait_rx_a(1, 100);
    st = rx_a[0].start;
    check("t1_data", rx_a[0].data, 8'hA5);
    check("t1_stop", rx_a[0].stop_ok, 1);
    check("t1_start_latency", st - t, 4);
    while (cyc < st + 10 * DIV_A - 1) @(negedge clk);
    check("t1_busy_last_stop", busy_a, 1);
    @(negedge clk);
    check("t1_busy_after_frame", busy_a, 0);
    check("t1_tx_idle", tx_a, 1);
    rx_a.delete();

    // Random nibble pairs on instance A against the packing model
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      n0 = 4'($urandom_range(0, 15));
      n1 = 4'($urandom_range(0, 15));
      send_a(n0, t);
      send_a(n1, t);
      exp_q.push_back(pack(1'b1, n0, n1));
    end
    wait_rx_a(4, 400);
    for (int i = 0; i < 4 && i < rx_a.size(); i++) begin
      check($sformatf("rand_a_data%0d", i), rx_a[i].data, exp_q[i]);
      check($sformatf("rand_a_stop%0d", i), rx_a[i].stop_ok, 1);
    end
    check("rand_a_ovf", ovf_a, 0);
    repeat (20) @(negedge clk);
    rx_a.delete();

    // Long-held valid yields a single nibble
    @(negedge clk);
    if_a.nib_data  = 4'h7;
    if_a.nib_valid = 1'b1;
    repeat (50) @(negedge clk);
    if_a.nib_valid = 1'b0;
    repeat (3) @(negedge clk);
    send_a(4'h1, t);
    wait_rx_a(1, 200);
    repeat (60) @(negedge clk);
    check("t4_count", rx_a.size(), 1);
    if (rx_a.size() > 0) check("t4_data", rx_a[0].data, 8'h71);
    rx_a.delete();

    // enable low discards a stale half-pair
    send_a(4'($urandom_range(0, 15)), t);
    enable_a = 1'b0;
    repeat (2) @(negedge clk);
    enable_a = 1'b1;
    send_a(4'h2, t);
    send_a(4'h4, t);
    wait_rx_a(1, 200);
    repeat (60) @(negedge clk);
    check("t5_count", rx_a.size(), 1);
    if (rx_a.size() > 0) check("t5_data", rx_a[0].data, 8'h24);
    check("t5_ovf", ovf_a, 0);
    rx_a.delete();

    // Instance B: first nibble goes low
    send_b(4'h3, t);
    send_b(4'hC, t);
    wait_rx_b(1, 1000);
    if (rx_b.size() > 0) begin
      check("t2_data", rx_b[0].data, 8'hC3);
      check("t2_stop", rx_b[0].stop_ok, 1);
    end
    k = 0;
    while (busy_b !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t2_idle", busy_b, 0);
    rx_b.delete();

    // Overflow: 12 quick nibbles, 5 bytes accepted, the 6th dropped
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      nibs[i] = 4'($urandom_range(0, 15));
      send_b(nibs[i], t);
    end
    for (int j = 0; j < 5; j++) exp_q.push_back(pack(1'b0, nibs[2*j], nibs[2*j+1]));
    check("t3_ovf", ovf_b, 1);
    check("t3_level", lvl_b, 4);
    wait_rx_b(5, 5 * 10 * DIV_B + 200);
    repeat (700) @(negedge clk);
    check("t3_count", rx_b.size(), 5);
    check("t3_busy_end", busy_b, 0);
    for (int j = 0; j < 5 && j < rx_b.size(); j++) begin
      check($sformatf("t3_data%0d", j), rx_b[j].data, exp_q[j]);
      if (j > 0) check($sformatf("t3_gap%0d", j), rx_b[j].start - rx_b[j-1].start, 10 * DIV_B);
    end
    check("t3_ovf_sticky", ovf_b, 1);
    enable_b = 1'b0;
    @(negedge clk);
    enable_b = 1'b1;
    check("t3_ovf_cleared", ovf_b, 0);
    rx_b.delete();

    // Reset during DATA bit 3
    send_a(4'($urandom_range(0, 15)), t);
    send_a(4'($urandom_range(0, 15)), t);
    k = 0;
    while (tx_a !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t6_frame_started", tx_a, 0);
    st = cyc;
    while (cyc < st + DIV_A * (1 + 3) + 1) @(negedge clk);
    check("t6_busy_before", busy_a, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_tx_in_reset", tx_a, 1);
    check("t6_busy_in_reset", busy_a, 0);
    check("t6_lvl_in_reset", lvl_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_busy_after", busy_a, 0);
    check("t6_lvl_after", lvl_a, 0);
    check("t6_tx_after", tx_a, 1);
    repeat (60) @(negedge clk);
    rx_a.delete();
    repeat (60) @(negedge clk);
    check("t6_no_frame", rx_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adpcm_uart_tx.md
Name: adpcm_uart_tx

Overview:
Output stage directly downstream of the CIC/ADPCM compressor. It takes each 4-bit encoded ADPCM sample and its valid strobe, and packs nibble pairs into bytes. Bytes go into a small FIFO and are sent off-chip as 8N1 UART frames on a single output pin. This turns the compressor's encPcm/outValid output into a stream a host can capture directly.

Parameters:
CLK_DIV, 16, clk cycles per UART bit (min 2)
FIFO_DEPTH, 4, byte FIFO entries (power of 2, min 2)
FIRST_NIBBLE_HIGH, 1, 1: first nibble of a pair goes to byte[7:4]; 0: to byte[3:0]

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  block enable; low flushes packer and FIFO
nib_valid  input  1  compressor outValid; may be asynchronous to clk or longer than one cycle
nib_data  input  4  compressor encPcm; stable while nib_valid is high
tx  output  1  UART serial out, idle high
busy  output  1  high while a frame is on tx or the FIFO is non-empty
overflow  output  1  sticky: a packed byte was dropped because the FIFO was full
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert inside the block): tx=1, busy=0, overflow=0, fifo_level=0, packer empty, FSM=IDLE.
- Input capture:
  - nib_valid passes through a 2-flop synchronizer, then a rising-edge detector.
  - On a detected edge with enable=1, nib_data is sampled. Capture happens 3 clk cycles after nib_valid rises.
  - A valid held high for many cycles yields exactly one nibble.
- Packer:
  - One held-nibble register plus a half flag.
  - Edge with half=0: store the nibble, set half=1.
  - Edge with half=1: form the byte per FIRST_NIBBLE_HIGH, push it to the FIFO, clear half.
- FIFO push/pop:
  - Push while full and no pop in the same cycle: byte dropped, overflow set.
  - Push and pop in the same cycle while full: both succeed, overflow unchanged.
  - Pop and push in the same cycle while empty cannot happen, because pop requires non-empty.
- enable=0:
  - Clears half and the held nibble, empties the FIFO, clears overflow, ignores input edges.
  - A frame already in progress completes, so tx never glitches; no new frame starts.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty and enable=1, pop into the shift register and go to START. tx goes low the cycle after the pop.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits LSB first, CLK_DIV cycles each, with a 3-bit bit counter.
  - STOP: tx=1 for CLK_DIV cycles.
  - Last STOP cycle: if the FIFO is non-empty and enable=1, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*CLK_DIV cycles. The baud counter is $clog2(CLK_DIV) bits and is reloaded at each bit boundary.
- busy = (FSM != IDLE) | (fifo_level != 0).
- Reset mid-frame: tx returns to 1 immediately (asynchronously); the partial frame is abandoned.

Decomposition:
- Package adpcm_pkg:
  - constants NIB_W=4, BYTE_W=8
  - enum uart_state_t {IDLE, START, DATA, STOP}
  - function clog2 for the level/counter widths
- One sub-module, adpcm_byte_fifo: synchronous FIFO with the same clk/rst_n, a flush input, push/pop/full/empty/level ports, and pointers one bit wider than the address.
- Synchronizer, packer and UART FSM stay in the top.

Test Plan:
1. CLK_DIV=4, enable=1, send nibble 0xA then 0x5 -> tx emits start 0, data bits 1,0,1,0,0,1,0,1, stop 1. The frame lasts 40 cycles, tx starts falling 1 cycle after the pop, and busy drops after the stop bit.
2. FIRST_NIBBLE_HIGH=0, send nibbles 0x3 then 0xC -> transmitted byte is 0xC3.
3. CLK_DIV=64, FIFO_DEPTH=4, send 12 nibbles quickly -> byte 1 is in flight, bytes 2-5 fill the FIFO, byte 6 is dropped. overflow=1 and fifo_level=4; all 5 accepted bytes then arrive back-to-back with no idle gap.
4. Hold nib_valid high for 50 cycles with nib_data=0x7, then pulse it again with 0x1 -> exactly one byte 0x71 is sent.
5. Send one nibble, then pull enable low for 2 cycles and raise it again, then send 0x2, 0x4 -> only 0x24 is sent. The stale nibble is discarded and overflow=0.
6. Assert rst_n=0 during DATA bit 3 -> tx=1 and busy=0 immediately. After release, the block is idle and fifo_level=0.
